// File: rtl/uart_pkg.sv
// uart_pkg: shared autobaud state encoding and sync-character constants (0x55 gives 9 edges, 9 bits x 16 oversampling = 144)
package uart_pkg;
  typedef enum logic [2:0] {IDLE, ARMED, MEASURE, DIVIDE, DONE} autobaud_state_e;
  localparam int AutobaudEdges = 9;
  localparam int AutobaudDenom = 144;
  localparam int AutobaudRound = 72;
endpackage

// File: rtl/uart_autobaud_div.sv
// uart_autobaud_div: restoring divider, first quotient bit in the start cycle, done_o pulses with quotient_o valid CntWidth cycles after start_i; ports clk_i, rst_i, start_i, dividend_i (CntWidth+1, MSB must be below divisor), divisor_i -> done_o, quotient_o
module uart_autobaud_div #(
  parameter int CntWidth = 20
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [CntWidth:0]   dividend_i,
  input  logic [CntWidth-1:0] divisor_i,
  output logic                done_o,
  output logic [CntWidth-1:0] quotient_o
);
  localparam int CW = $clog2(CntWidth + 1);
  logic [CntWidth-1:0] rem, rem_n, quo, cur_r, cur_q;
  logic [CntWidth:0] trial;
  logic [CW-1:0] cnt;
  logic busy, qbit, last;
  always_comb begin
    cur_r = start_i ? {{(CntWidth-1){1'b0}}, dividend_i[CntWidth]} : rem;
    cur_q = start_i ? dividend_i[CntWidth-1:0] : quo;
    trial = {cur_r, cur_q[CntWidth-1]};
    qbit = trial >= {1'b0, divisor_i};
    rem_n = qbit ? trial[CntWidth-1:0] - divisor_i : trial[CntWidth-1:0];
    last = busy && (cnt == CW'(CntWidth - 1));
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rem <= '0;
      quo <= '0;
      cnt <= '0;
      busy <= 1'b0;
      done_o <= 1'b0;
    end else begin
      if (start_i || busy) begin
        rem <= rem_n;
        quo <= {cur_q[CntWidth-2:0], qbit};
      end
      cnt <= start_i ? CW'(1) : cnt + 1'b1;
      busy <= start_i || (busy && !last);
      done_o <= !start_i && last;
    end
  end
  assign quotient_o = quo;
endmodule

// File: rtl/uart_autobaud.sv
// uart_autobaud: 0x55 autobaud detector; clk_i, rst_i, start_i, rxd_i -> rxd_o (synced line), busy_o, done_o, err_o, divisor_o (16x DLL/DLM), bit_cycles_o; UART_AUTOBAUD_FILTER_EN adds a 3-sample majority glitch filter
module uart_autobaud
  import uart_pkg::*;
#(
  parameter int CntWidth = 20,
  parameter int MinBitCycles = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                rxd_i,
  output logic                rxd_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [15:0]         divisor_o,
  output logic [CntWidth-1:0] bit_cycles_o
);
  autobaud_state_e state, state_n;
  logic [1:0] sync;
  logic rxl, rxl_d, hi_seen, rx_edge, seg_bad, tmo, meas_err, last_edge, div_start, div_done, div_bad;
  logic [CntWidth-1:0] seg, total, first, diff, quo;
  logic [CntWidth:0] dividend;
  logic [3:0] ecnt;
`ifdef UART_AUTOBAUD_FILTER_EN
  logic [1:0] hist;
  logic maj;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hist <= 2'b11;
      maj <= 1'b1;
    end else begin
      hist <= {hist[0], sync[1]};
      maj <= (sync[1] & hist[0]) | (sync[1] & hist[1]) | (hist[0] & hist[1]);
    end
  end
  assign rxl = maj;
`else
  assign rxl = sync[1];
`endif
  assign rxd_o = rxl;
  assign done_o = state == DONE;
  always_comb begin
    rx_edge = rxl ^ rxl_d;
    diff = (seg > first) ? seg - first : first - seg;
    seg_bad = (ecnt == '0) ? (seg < CntWidth'(MinBitCycles)) : (diff > (first >> 2));
    tmo = (ecnt != '0) && ({1'b0, seg} == {first, 1'b0});
    meas_err = tmo || (&total) || (rx_edge && seg_bad);
    last_edge = rx_edge && (ecnt == 4'(AutobaudEdges - 1));
    div_start = (state == MEASURE) && !meas_err && last_edge;
    div_bad = (quo == '0) || ((quo >> 16) != '0);
    dividend = {1'b0, total} + (CntWidth+1)'(AutobaudRound);
    state_n = state;
    case (state)
      IDLE:    state_n = start_i ? ARMED : IDLE;
      ARMED:   state_n = (hi_seen && !rxl) ? MEASURE : ARMED;
      MEASURE: state_n = meas_err ? DONE : last_edge ? DIVIDE : MEASURE;
      DIVIDE:  state_n = div_done ? DONE : DIVIDE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync <= 2'b11;
      rxl_d <= 1'b1;
      hi_seen <= 1'b0;
      seg <= '0;
      total <= '0;
      first <= '0;
      ecnt <= '0;
      busy_o <= 1'b0;
      err_o <= 1'b0;
      divisor_o <= '0;
      bit_cycles_o <= '0;
    end else begin
      sync <= {sync[0], rxd_i};
      rxl_d <= rxl;
      busy_o <= state_n != IDLE;
      hi_seen <= (state == ARMED) && (hi_seen || rxl);
      if (state == IDLE && start_i) err_o <= 1'b0;
      if (state == ARMED) begin
        seg <= CntWidth'(1);
        total <= CntWidth'(1);
        ecnt <= '0;
      end
      if (state == MEASURE) begin
        seg <= rx_edge ? CntWidth'(1) : seg + 1'b1;
        total <= total + 1'b1;
        ecnt <= ecnt + 4'(rx_edge);
        if (rx_edge && ecnt == '0) first <= seg;
        if (meas_err) err_o <= 1'b1;
      end
      if (state == DIVIDE && div_done) begin
        err_o <= div_bad;
        if (!div_bad) begin
          divisor_o <= 16'(quo);
          bit_cycles_o <= first;
        end
      end
    end
  end
  uart_autobaud_div #(.CntWidth(CntWidth)) u_div (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (div_start),
    .dividend_i(dividend),
    .divisor_i (CntWidth'(AutobaudDenom)),
    .done_o    (div_done),
    .quotient_o(quo)
  );
endmodule
